lut_neuron_layer: RTL

Parametrised, pipelined layer of LogicNets truth-table neurons with run-time loadable tables. Each of `NUM_NEURONS` neurons maps an `ADDR_W`-bit gathered input address to an `OUT_W`-bit output through its own table. Replaces per-neuron hard-coded ROM modules, so one bitstream serves retrained networks. Sits between the input-gather stage and the next layer, with valid/ready on both sides.

---
 rtl/lut_layer_pkg.sv | 15 +
 rtl/lut_table_ram.sv | 27 ++
 rtl/lut_neuron_layer.sv | 123 ++++++++++++
 3 files changed

// File: rtl/lut_layer_pkg.sv
// Shared types and helpers for the LUT neuron layer.
package lut_layer_pkg;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // Neuron select width; never narrower than one bit.
    function automatic int unsigned NEURON_IDX_W(input int unsigned num_neurons);
        return (num_neurons > 1) ? $clog2(num_neurons) : 1;
    endfunction

endpackage

// File: rtl/lut_table_ram.sv
// One neuron's truth table: synchronous write, asynchronous read (distributed RAM).
module lut_table_ram #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned OUT_W  = 1
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [OUT_W-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [OUT_W-1:0]  rdata
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    // Contents are deliberately not reset so tables survive a layer reset.
    logic [OUT_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/lut_neuron_layer.sv
// Pipelined layer of run-time loadable truth-table neurons with a LOAD/RUN/DRAIN
// controller and valid/ready handshakes on both sides.
module lut_neuron_layer
    import lut_layer_pkg::*;
#(
    parameter int unsigned NUM_NEURONS = 8,
    parameter int unsigned ADDR_W      = 6,
    parameter int unsigned OUT_W       = 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [NUM_NEURONS*ADDR_W-1:0]       in_data,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [NUM_NEURONS*OUT_W-1:0]        out_data,
    input  logic                                cfg_we,
    input  logic [NEURON_IDX_W(NUM_NEURONS)-1:0] cfg_neuron,
    input  logic [ADDR_W-1:0]                   cfg_addr,
    input  logic [OUT_W-1:0]                    cfg_data,
    input  logic                                cfg_done,
    input  logic                                cfg_reload,
    output logic                                loaded
);

    localparam int unsigned IDX_W = NEURON_IDX_W(NUM_NEURONS);
    localparam int unsigned IN_W  = NUM_NEURONS * ADDR_W;
    localparam int unsigned RES_W = NUM_NEURONS * OUT_W;

    state_e           state_q, state_d;
    logic             s1_valid_q, s1_valid_d;
    logic [IN_W-1:0]  s1_addr_q, s1_addr_d;
    logic             s2_valid_q, s2_valid_d;
    logic [RES_W-1:0] s2_data_q, s2_data_d;
    logic             loaded_q, loaded_d;

    logic [RES_W-1:0] lookup_c;
    logic             s2_free_c;
    logic             s1_adv_c;
    logic             in_fire_c;
    logic             cfg_ok_c;

    // Handshake: a stage may load when empty or when it empties this cycle.
    always_comb begin
        s2_free_c = !s2_valid_q || out_ready;
        s1_adv_c  = s1_valid_q && s2_free_c;
        in_ready  = (state_q == ST_RUN) && (!s1_valid_q || s1_adv_c);
        in_fire_c = in_valid && in_ready;
        cfg_ok_c  = (state_q == ST_LOAD) && cfg_we
                    && ({1'b0, cfg_neuron} < (IDX_W + 1)'(NUM_NEURONS));
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_LOAD:  if (cfg_done)   state_d = ST_RUN;
            ST_RUN:   if (cfg_reload) state_d = ST_DRAIN;
            ST_DRAIN: if (!s1_valid_q && !s2_valid_q) state_d = ST_LOAD;
            default:  state_d = ST_LOAD;
        endcase
        loaded_d = (state_d == ST_RUN);
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_addr_d  = s1_addr_q;
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        if (in_fire_c) begin
            s1_valid_d = 1'b1;
            s1_addr_d  = in_data;
        end else if (s1_adv_c) begin
            s1_valid_d = 1'b0;
        end
        if (s1_adv_c) begin
            s2_valid_d = 1'b1;
            s2_data_d  = lookup_c;
        end else if (out_ready) begin
            s2_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_LOAD;
            s1_valid_q <= 1'b0;
            s1_addr_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            loaded_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            s1_valid_q <= s1_valid_d;
            s1_addr_q  <= s1_addr_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            loaded_q   <= loaded_d;
        end
    end

    for (genvar n = 0; n < NUM_NEURONS; n++) begin : g_neuron
        logic we_c;
        assign we_c = cfg_ok_c && (cfg_neuron == IDX_W'(n));

        lut_table_ram #(
            .ADDR_W (ADDR_W),
            .OUT_W  (OUT_W)
        ) u_ram (
            .clk   (clk),
            .we    (we_c),
            .waddr (cfg_addr),
            .wdata (cfg_data),
            .raddr (s1_addr_q[n*ADDR_W +: ADDR_W]),
            .rdata (lookup_c[n*OUT_W +: OUT_W])
        );
    end

    assign out_valid = s2_valid_q;
    assign out_data  = s2_data_q;
    assign loaded    = loaded_q;

endmodule
